// File: rtl/ps2_kbd_decoder_pkg.sv
// Shared constants, fetch-state encoding and event classification for the PS/2 set-2 decoder.
// Pure definitions; no logic, no latency.
package kbd_pkg;

   localparam logic [7:0] KBD_BREAK = 8'hF0;
   localparam logic [7:0] KBD_EXT   = 8'hE0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] POP  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   typedef enum logic [1:0] {
      EVT_NONE   = 2'd0,
      EVT_MAKE   = 2'd1,
      EVT_BREAK  = 2'd2,
      EVT_REPEAT = 2'd3
   } evt_type_e;

   typedef struct packed {
      logic       brk;
      logic       rep;
      logic       ext;
      logic [7:0] code;
   } evt_t;

   // held_hit: {ext_pend, byte} names the key that is currently held down
   function automatic evt_type_e classify(input logic [7:0] b,
                                          input logic       brk_pend,
                                          input logic       held_hit);
      if (b == KBD_BREAK || b == KBD_EXT) return EVT_NONE;
      if (brk_pend)                       return EVT_BREAK;
      if (held_hit)                       return EVT_REPEAT;
      return EVT_MAKE;
   endfunction

endpackage

// File: rtl/ps2_kbd_decoder_ascii_rom.sv
// Set-2 scancode to lowercase ASCII table (letters, digits, space, enter); 0 when unmapped.
// Combinational, zero latency.
module kbd_ascii_rom (
   input  logic [7:0] scancode,
   input  logic       unused_tie,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      case (scancode)
         8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         default: ascii = {7'd0, unused_tie & 1'b0};
      endcase
   end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 decoder draining ps2_keyboard's FIFO: one byte per 3 cycles (IDLE/POP/GAP), events one cycle after the pop.
// No backpressure on events; key_ascii comes from kbd_ascii_rom only when KBD_DEC_ASCII_EN is defined.
module ps2_kbd_decoder
   import kbd_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int REPEAT_EVT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_ready,
   input  logic             ps2_overflow,
   output logic             ps2_nextdata_n,
   output logic             evt_valid,
   output logic             evt_break,
   output logic             evt_repeat,
   output logic             evt_ext,
   output logic [7:0]       evt_code,
   output logic             key_pressed,
   output logic [7:0]       key_code,
   output logic [7:0]       key_ascii,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow_seen
);

   logic [1:0]       state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic             brk_pend_q, brk_pend_d;
   logic             ext_pend_q, ext_pend_d;
   logic             evt_valid_q, evt_valid_d;
   evt_t             evt_q, evt_d;
   logic             key_pressed_q, key_pressed_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             overflow_seen_q, overflow_seen_d;

   logic             held_hit;
   evt_type_e        etype;

   assign held_hit = key_pressed_q && ({ext_pend_q, byte_q} == {key_ext_q, key_code_q});

   always_comb begin
      state_d         = state_q;
      byte_d          = byte_q;
      nextdata_n_d    = 1'b1;
      brk_pend_d      = brk_pend_q;
      ext_pend_d      = ext_pend_q;
      evt_valid_d     = 1'b0;
      evt_d           = evt_q;
      key_pressed_d   = key_pressed_q;
      key_code_d      = key_code_q;
      key_ext_d       = key_ext_q;
      press_count_d   = press_count_q;
      overflow_seen_d = overflow_seen_q | ps2_overflow;
      etype           = EVT_NONE;

      case (state_q)
         IDLE: begin
            if (ps2_ready) begin
               byte_d       = ps2_data;
               nextdata_n_d = 1'b0;
               state_d      = POP;
            end
         end
         POP: begin
            state_d = GAP;
            etype   = classify(byte_q, brk_pend_q, held_hit);

            if (byte_q == KBD_BREAK) begin
               brk_pend_d = 1'b1;
            end else if (byte_q == KBD_EXT) begin
               ext_pend_d = 1'b1;
            end else begin
               brk_pend_d = 1'b0;
               ext_pend_d = 1'b0;
            end

            // Repeats still consume the byte when reporting them is disabled
            if (etype != EVT_NONE && (etype != EVT_REPEAT || REPEAT_EVT != 0)) begin
               evt_valid_d = 1'b1;
               evt_d.brk   = (etype == EVT_BREAK);
               evt_d.rep   = (etype == EVT_REPEAT);
               evt_d.ext   = ext_pend_q;
               evt_d.code  = byte_q;
            end

            if (etype == EVT_BREAK && held_hit) begin
               key_pressed_d = 1'b0;
            end

            if (etype == EVT_MAKE) begin
               key_pressed_d = 1'b1;
               key_code_d    = byte_q;
               key_ext_d     = ext_pend_q;
               press_count_d = press_count_q + CNT_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         byte_q          <= 8'h00;
         nextdata_n_q    <= 1'b1;
         brk_pend_q      <= 1'b0;
         ext_pend_q      <= 1'b0;
         evt_valid_q     <= 1'b0;
         evt_q           <= '0;
         key_pressed_q   <= 1'b0;
         key_code_q      <= 8'h00;
         key_ext_q       <= 1'b0;
         press_count_q   <= '0;
         overflow_seen_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         byte_q          <= byte_d;
         nextdata_n_q    <= nextdata_n_d;
         brk_pend_q      <= brk_pend_d;
         ext_pend_q      <= ext_pend_d;
         evt_valid_q     <= evt_valid_d;
         evt_q           <= evt_d;
         key_pressed_q   <= key_pressed_d;
         key_code_q      <= key_code_d;
         key_ext_q       <= key_ext_d;
         press_count_q   <= press_count_d;
         overflow_seen_q <= overflow_seen_d;
      end
   end

   assign ps2_nextdata_n = nextdata_n_q;
   assign evt_valid      = evt_valid_q;
   assign evt_break      = evt_q.brk;
   assign evt_repeat     = evt_q.rep;
   assign evt_ext        = evt_q.ext;
   assign evt_code       = evt_q.code;
   assign key_pressed    = key_pressed_q;
   assign key_code       = key_code_q;
   assign press_count    = press_count_q;
   assign overflow_seen  = overflow_seen_q;

`ifdef KBD_DEC_ASCII_EN
   logic [7:0] rom_ascii;

   kbd_ascii_rom u_ascii_rom (
      .scancode   (key_code_q),
      .unused_tie (1'b0),
      .ascii      (rom_ascii)
   );

   assign key_ascii = key_ext_q ? 8'h00 : rom_ascii;
`else
   assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: FIFO model feeding bytes, sequence-level reference decoder, event scoreboard.
module tb_ps2_kbd_decoder;

   localparam int CNT_W = 8;
   localparam int REP   = 1;
`ifdef KBD_DEC_ASCII_EN
   localparam bit ASCII_EN = 1'b1;
`else
   localparam bit ASCII_EN = 1'b0;
`endif

   localparam logic [7:0] LET_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                          8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                          8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                          8'h35, 8'h1A};
   localparam logic [7:0] DIG_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                          8'h3E, 8'h46};
   localparam logic [7:0] POOL [6]    = '{8'h1C, 8'h1B, 8'h75, 8'h29, 8'h5A, 8'h16};

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       ps2_data = 8'h00;
   logic             ps2_ready = 1'b0;
   logic             ps2_overflow = 1'b0;
   logic             ps2_nextdata_n;
   logic             evt_valid, evt_break, evt_repeat, evt_ext;
   logic [7:0]       evt_code, key_code, key_ascii;
   logic             key_pressed, overflow_seen;
   logic [CNT_W-1:0] press_count;

   ps2_kbd_decoder #(.CNT_W(CNT_W), .REPEAT_EVT(REP)) dut (
      .clock          (clock),
      .reset          (reset),
      .ps2_data       (ps2_data),
      .ps2_ready      (ps2_ready),
      .ps2_overflow   (ps2_overflow),
      .ps2_nextdata_n (ps2_nextdata_n),
      .evt_valid      (evt_valid),
      .evt_break      (evt_break),
      .evt_repeat     (evt_repeat),
      .evt_ext        (evt_ext),
      .evt_code       (evt_code),
      .key_pressed    (key_pressed),
      .key_code       (key_code),
      .key_ascii      (key_ascii),
      .press_count    (press_count),
      .overflow_seen  (overflow_seen)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       brk;
      logic       rep;
      logic       ext;
      logic [7:0] code;
   } ev_t;

   ev_t        expq[$];
   logic [7:0] bq[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         n_evt = 0;
   int         n_rep = 0;
   int         n_lo = 0;
   bit         model_en = 1'b1;
   logic       prev_nd = 1'b1;

   bit         m_pressed, m_ext, m_brk, m_extp;
   logic [7:0] m_code;
   int         m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_ascii(input logic [7:0] c, input logic e);
      exp_ascii = 8'h00;
      if (ASCII_EN && !e) begin
         for (int i = 0; i < 26; i++) if (LET_SC[i] == c) exp_ascii = 8'(8'h61 + i);
         for (int i = 0; i < 10; i++) if (DIG_SC[i] == c) exp_ascii = 8'(8'h30 + i);
         if (c == 8'h29) exp_ascii = 8'h20;
         if (c == 8'h5A) exp_ascii = 8'h0D;
      end
   endfunction

   task automatic model_reset();
      m_pressed = 0; m_ext = 0; m_brk = 0; m_extp = 0; m_code = 8'h00; m_count = 0;
      expq.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      bit  same;
      if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'hE0) begin
         m_extp = 1;
      end else begin
         same   = m_pressed && (m_extp == m_ext) && (b == m_code);
         e.code = b;
         e.ext  = m_extp;
         e.brk  = 0;
         e.rep  = 0;
         if (m_brk) begin
            e.brk = 1;
            expq.push_back(e);
            if (same) m_pressed = 0;
         end else if (same) begin
            e.rep = 1;
            if (REP != 0) expq.push_back(e);
         end else begin
            expq.push_back(e);
            m_code    = b;
            m_ext     = m_extp;
            m_pressed = 1;
            m_count   = (m_count + 1) % (1 << CNT_W);
         end
         m_brk  = 0;
         m_extp = 0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      bq.push_back(b);
      ps2_ready = 1'b1;
      ps2_data  = bq[0];
   endtask

   // One clock: the FIFO pops on the edge that ends a low nextdata_n cycle
   task automatic cyc();
      logic [7:0] b;
      ev_t        e;
      @(posedge clock);
      if (!prev_nd && bq.size() != 0) begin
         b = bq.pop_front();
         if (model_en) model_byte(b);
      end
      #1;
      if (!prev_nd) check("nd_low_one_cycle", 32'(ps2_nextdata_n), 32'd1);
      if (!ps2_nextdata_n) n_lo++;
      if (evt_valid) begin
         n_evt++;
         if (evt_repeat) n_rep++;
         if (expq.size() == 0) begin
            check("unexpected_evt", {23'd0, evt_break, evt_code}, 32'hFFFF_FFFF);
         end else begin
            e = expq.pop_front();
            check("evt_code",   32'(evt_code),   32'(e.code));
            check("evt_break",  32'(evt_break),  32'(e.brk));
            check("evt_repeat", 32'(evt_repeat), 32'(e.rep));
            check("evt_ext",    32'(evt_ext),    32'(e.ext));
         end
      end
      prev_nd   = ps2_nextdata_n;
      ps2_ready = (bq.size() != 0);
      ps2_data  = (bq.size() != 0) ? bq[0] : 8'h00;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((bq.size() != 0 || !prev_nd) && k < 5000) begin
         cyc();
         k++;
      end
      cyc(); cyc(); cyc();
      check("drain_within_budget", 32'(k < 5000), 32'd1);
      check("all_events_seen",     32'(expq.size()), 32'd0);
      check("key_pressed",         32'(key_pressed), 32'(m_pressed));
      check("key_code",            32'(key_code),    32'(m_code));
      check("press_count",         32'(press_count), 32'(m_count));
      check("key_ascii",           32'(key_ascii),   32'(exp_ascii(m_code, m_ext)));
   endtask

   task automatic check_reset_outputs();
      check("rst_nextdata_n",   32'(ps2_nextdata_n), 32'd1);
      check("rst_evt_valid",    32'(evt_valid),      32'd0);
      check("rst_evt_fields",   {28'd0, evt_break, evt_repeat, evt_ext, 1'b0}, 32'd0);
      check("rst_evt_code",     32'(evt_code),       32'd0);
      check("rst_key_pressed",  32'(key_pressed),    32'd0);
      check("rst_key_code",     32'(key_code),       32'd0);
      check("rst_key_ascii",    32'(key_ascii),      32'd0);
      check("rst_press_count",  32'(press_count),    32'd0);
      check("rst_overflow",     32'(overflow_seen),  32'd0);
   endtask

   initial begin
      logic [7:0] c, last;
      int         r;

      model_reset();
      reset = 1'b1;
      cyc(); cyc(); cyc();
      check_reset_outputs();
      reset = 1'b0;
      cyc();

      // Single make: pop strobe exactly one cycle, event the cycle after
      n_lo = 0; n_evt = 0;
      send(8'h1C);
      cyc();
      check("t1_pop_low",      32'(ps2_nextdata_n), 32'd0);
      check("t1_no_evt_early", 32'(evt_valid),      32'd0);
      cyc();
      check("t1_evt_valid",    32'(evt_valid),      32'd1);
      drain();
      check("t1_low_cycles",   32'(n_lo),           32'd1);
      check("t1_evt_count",    32'(n_evt),          32'd1);
      check("t1_ascii",        32'(key_ascii),      ASCII_EN ? 32'h61 : 32'h00);
      check("t1_count",        32'(press_count),    32'd1);

      // Release of the held key
      n_evt = 0;
      send(8'hF0); send(8'h1C);
      drain();
      check("t2_evt_count",  32'(n_evt),       32'd1);
      check("t2_released",   32'(key_pressed), 32'd0);
      check("t2_code_kept",  32'(key_code),    32'h1C);

      // Typematic repeats
      n_evt = 0; n_rep = 0;
      send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
      drain();
      check("t3_evt_count", 32'(n_evt),       (REP != 0) ? 32'd4 : 32'd2);
      check("t3_rep_count", 32'(n_rep),       (REP != 0) ? 32'd2 : 32'd0);
      check("t3_count",     32'(press_count), 32'd2);

      // Extended key make/release
      send(8'hE0); send(8'h75);
      drain();
      check("t4_ext_ascii",   32'(key_ascii),   32'd0);
      check("t4_ext_pressed", 32'(key_pressed), 32'd1);
      send(8'hE0); send(8'hF0); send(8'h75);
      drain();
      check("t4_ext_release", 32'(key_pressed), 32'd0);

      // Reset landing on the POP cycle discards that byte
      n_evt = 0;
      send(8'h1C);
      cyc();
      check("t5_in_pop", 32'(ps2_nextdata_n), 32'd0);
      reset    = 1'b1;
      model_en = 1'b0;
      cyc();
      check_reset_outputs();
      reset = 1'b0;
      model_reset();
      model_en = 1'b1;
      cyc(); cyc();
      check("t5_no_evt", 32'(n_evt), 32'd0);
      send(8'h1B);
      drain();
      check("t5_count_after", 32'(press_count), 32'd1);

      // Sticky overflow
      ps2_overflow = 1'b1;
      cyc();
      ps2_overflow = 1'b0;
      check("t6_ovf_set", 32'(overflow_seen), 32'd1);
      for (int i = 0; i < 6; i++) cyc();
      check("t6_ovf_sticky", 32'(overflow_seen), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      model_reset();
      check("t6_ovf_cleared", 32'(overflow_seen), 32'd0);
      cyc();

      // 256 distinct presses wrap the counter
      last = 8'h00;
      for (int i = 0; i < 256; i++) begin
         do c = 8'($urandom_range(1, 255));
         while (c == 8'hF0 || c == 8'hE0 || c == last);
         send(c);
         last = c;
      end
      drain();
      check("t7_wrap", 32'(press_count), 32'd0);

      // Random mixed stream from a small key pool
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25) send(8'hE0);
         r = $urandom_range(0, 99);
         if (r < 30) send(8'hF0);
         send(POOL[$urandom_range(0, 5)]);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
